ascii_hex_parser: RTL and testbench
===================================

// Module: ascii_hex_parser
// PURPOSE
//   Inverse of the hex-nibble-to-ASCII encoder: consumes a byte stream of ASCII
//   characters (e.g. from the UART receiver) and assembles hex-digit runs into
//   binary words for the DSP command/coefficient path.
//   Digits are accumulated MSB-first; a delimiter closes the word and presents
//   it on a valid/ready output. Invalid characters and over-length runs are
//   flagged.
// PARAMETERS
//   WORD_W      16   output word width in bits; multiple of 4, range 4..32
//   MAX_DIGITS  WORD_W/4   digits accepted per word before overflow
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst_n        in   1        synchronous reset, active low
//   char_in      in   8        ASCII character
//   char_valid   in   1        char_in valid this cycle
//   char_ready   out  1        parser can accept a character
//   word_out     out  WORD_W   assembled word, zero-extended on the left
//   word_digits  out  4        number of digits in word_out (1..MAX_DIGITS)
//   word_ovf     out  1        word had more than MAX_DIGITS digits
//   word_valid   out  1        word_out/word_digits/word_ovf valid
//   word_ready   in   1        downstream accepts word
//   err_invalid  out  1        one-cycle pulse: non-hex, non-delimiter char seen
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, acc=0, count=0, ovf=0;
//     word_valid=0, word_out=0, word_digits=0, word_ovf=0, err_invalid=0,
//     char_ready=1. Reset mid-word or mid-hold discards everything.
//   Char accept: char_valid & char_ready at an edge. char_ready = (state!=HOLD).
//   Classes: digit = 0x30-0x39 -> 0-9, 0x41-0x46 and 0x61-0x66 -> A-F;
//     delimiter = 0x0D, 0x0A, 0x20, 0x2C; anything else = invalid.
//   IDLE: delimiter ignored (no output). Digit: acc<={0,nib}, count=1 -> ACCUM.
//     Invalid: err_invalid pulses next cycle, stay IDLE.
//   ACCUM: digit with count<MAX_DIGITS: acc<={acc[WORD_W-5:0],nib}, count+1.
//     Digit with count==MAX_DIGITS: acc/count unchanged, ovf<=1 (digit dropped).
//     Delimiter: word_out<=acc, word_digits<=count, word_ovf<=ovf,
//       word_valid<=1 -> HOLD. Latency: word_valid high in the cycle after the
//       delimiter's accept edge.
//     Invalid: err_invalid pulse, acc/count/ovf cleared, -> IDLE (no word).
//   HOLD: char_ready=0; outputs stable while word_valid & !word_ready.
//     word_valid & word_ready at an edge: word_valid<=0, acc/count/ovf cleared,
//     -> IDLE; char_ready=1 in the following cycle (one bubble per word).
//   err_invalid is a registered single-cycle pulse, independent of word_ready.
//   char_valid while char_ready=0: ignored; upstream must hold the byte.
//   word_ready while word_valid=0: no effect.
//   Lowercase and uppercase A-F decode identically.
// TESTING
//   1 reset, stream "1A3F\r" (WORD_W=16) -> word_out=16'h1A3F, digits=4,
//     ovf=0, word_valid one cycle after the '\r' accept.
//   2 "  7,", word_ready=1 -> leading spaces ignored, word_out=16'h0007,
//     digits=1; char_ready low exactly one cycle.
//   3 "12345 " -> word_out=16'h1234, digits=4, word_ovf=1.
//   4 "1G2\n" -> err_invalid single pulse after 'G', no word for "1";
//     then "2" emits word_out=16'h0002.
//   5 "ab\n" with word_ready=0 for 10 cycles, char_valid held high with 'C' ->
//     word_out=16'h00AB stable, char_ready=0, 'C' accepted only after handshake.
//   6 "12" then rst_n=0 one cycle, then "3\r" -> word_out=16'h0003, digits=1.

Source files
------------

// File: rtl/ascii_hex_parser.sv
// ASCII hex-run to binary word parser: digits accumulate MSB-first, a delimiter
// closes the word onto a valid/ready output, stray characters pulse err_invalid.
module ascii_hex_parser #(
  parameter int WORD_W     = 16,
  parameter int MAX_DIGITS = WORD_W / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [WORD_W-1:0] word_out,
  output logic [3:0]        word_digits,
  output logic              word_ovf,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_invalid,
  output logic [1:0]        dbg_state
);

  // Handshakes: a character moves on an edge with char_valid & char_ready,
  // a word moves on an edge with word_valid & word_ready; the sender holds
  // its payload stable until that edge.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_acc, w_acc_nxt;
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic [3:0]        r_count, w_count_nxt;
  logic [3:0]        r_digits, w_digits_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_wovf, w_wovf_nxt;
  logic              r_wvalid, w_wvalid_nxt;
  logic              r_err, w_err_nxt;

  logic       w_is_num, w_is_alpha, w_is_hex, w_is_delim, w_accept;
  logic [3:0] w_nib;

  assign w_is_num   = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign w_is_alpha = ((char_in >= 8'h41) && (char_in <= 8'h46)) ||
                      ((char_in >= 8'h61) && (char_in <= 8'h66));
  assign w_is_hex   = w_is_num || w_is_alpha;
  assign w_is_delim = (char_in == 8'h0D) || (char_in == 8'h0A) ||
                      (char_in == 8'h20) || (char_in == 8'h2C);
  // Both letter cases carry 1..6 in the low nibble for A..F.
  assign w_nib      = w_is_alpha ? (char_in[3:0] + 4'd9) : char_in[3:0];
  assign w_accept   = char_valid && (r_state != S_HOLD);

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_ovf;
    w_word_nxt   = r_word;
    w_digits_nxt = r_digits;
    w_wovf_nxt   = r_wovf;
    w_wvalid_nxt = r_wvalid;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_hex) begin
            w_acc_nxt   = WORD_W'(w_nib);
            w_count_nxt = 4'd1;
            w_state_nxt = S_ACCUM;
          end else if (!w_is_delim) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          if (w_is_hex) begin
            if (r_count < MAX_CNT) begin
              w_acc_nxt   = (r_acc << 4) | WORD_W'(w_nib);
              w_count_nxt = r_count + 4'd1;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end else if (w_is_delim) begin
            w_word_nxt   = r_acc;
            w_digits_nxt = r_count;
            w_wovf_nxt   = r_ovf;
            w_wvalid_nxt = 1'b1;
            w_state_nxt  = S_HOLD;
          end else begin
            w_err_nxt   = 1'b1;
            w_acc_nxt   = '0;
            w_count_nxt = 4'd0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (word_ready) begin
          w_wvalid_nxt = 1'b0;
          w_acc_nxt    = '0;
          w_count_nxt  = 4'd0;
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_count  <= 4'd0;
      r_ovf    <= 1'b0;
      r_word   <= '0;
      r_digits <= 4'd0;
      r_wovf   <= 1'b0;
      r_wvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_count  <= w_count_nxt;
      r_ovf    <= w_ovf_nxt;
      r_word   <= w_word_nxt;
      r_digits <= w_digits_nxt;
      r_wovf   <= w_wovf_nxt;
      r_wvalid <= w_wvalid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign char_ready  = (r_state != S_HOLD);
  assign word_out    = r_word;
  assign word_digits = r_digits;
  assign word_ovf    = r_wovf;
  assign word_valid  = r_wvalid;
  assign err_invalid = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: directed scenarios with literal expectations plus a
// random character stream checked every cycle against a string-level model.
module tb_ascii_hex_parser;

  localparam int WORD_W = 16;
  localparam int MAXD   = WORD_W / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        char_in = 8'h00;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic [WORD_W-1:0] word_out;
  logic [3:0]        word_digits;
  logic              word_ovf;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              err_invalid;
  logic [1:0]        dbg_state;

  ascii_hex_parser #(.WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .word_out(word_out), .word_digits(word_digits),
    .word_ovf(word_ovf), .word_valid(word_valid), .word_ready(word_ready),
    .err_invalid(err_invalid), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // counters and scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int hs_cnt   = 0;
  logic chk_en  = 1'b0;
  logic rand_rdy = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] last_word = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  // behavioural model: a list of pending digit values per run
  int   run[$];
  bit   hold = 0, m_ovf = 0, m_valid = 0, m_wovf = 0, m_err = 0;
  int   m_word = 0, m_digits = 0;
  int   k, v;

  function automatic int classify(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c == 8'h0D || c == 8'h0A || c == " " || c == ",") return 16;
    return 17;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      hold = 0; run.delete(); m_ovf = 0; m_valid = 0; m_wovf = 0; m_err = 0;
      m_word = 0; m_digits = 0; exp_q.delete();
    end else begin
      m_err = 0;
      if (hold) begin
        if (word_ready) begin hold = 0; m_valid = 0; end
      end else if (char_valid) begin
        k = classify(char_in);
        if (k < 16) begin
          if (run.size() < MAXD) run.push_back(k);
          else m_ovf = 1;
        end else if (k == 16) begin
          if (run.size() > 0) begin
            v = 0;
            foreach (run[i]) v = v * 16 + run[i];
            m_word = v; m_digits = run.size(); m_wovf = m_ovf;
            m_valid = 1; hold = 1;
            exp_q.push_back({m_wovf, 4'(m_digits), 16'(m_word)});
            run.delete(); m_ovf = 0;
          end
        end else begin
          m_err = 1; run.delete(); m_ovf = 0;
        end
      end
    end
  end

  // per-cycle compare and word scoreboard
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("char_ready", char_ready, !hold);
      check("word_valid", word_valid, m_valid);
      check("err_invalid", err_invalid, m_err);
      if (m_valid) begin
        check("word_out", word_out, m_word);
        check("word_digits", word_digits, m_digits);
        check("word_ovf", word_ovf, m_wovf);
      end
      if (err_invalid) err_cnt++;
      if (word_valid && word_ready) begin
        hs_cnt++;
        last_word = {word_ovf, word_digits, word_out};
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sb_word", last_word, exp_q.pop_front());
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    logic rdy;
    int n;
    char_in = c; char_valid = 1'b1; n = 0;
    do begin
      @(negedge clk); rdy = char_ready;
      @(posedge clk); #1; n++;
      if (rand_rdy) word_ready = ($urandom_range(0, 3) != 0);
    end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", rdy, 1);
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  int e0, h0, r, d;
  logic [7:0] c;

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_out", word_out, 0);
    check("rst_word_digits", word_digits, 0);
    check("rst_word_ovf", word_ovf, 0);
    check("rst_err", err_invalid, 0);
    check("rst_char_ready", char_ready, 1);
    step();

    // 1: "1A3F\r", latency one cycle after the delimiter accept
    word_ready = 1'b0;
    send_str("1A3F");
    send_char(8'h0D);
    @(negedge clk);
    check("t1_valid", word_valid, 1);
    check("t1_word", word_out, 32'h1A3F);
    check("t1_digits", word_digits, 4);
    check("t1_ovf", word_ovf, 0);
    step(); word_ready = 1'b1; step(); word_ready = 1'b0;
    check("t1_sb", last_word, {1'b0, 4'd4, 16'h1A3F});

    // 2: leading spaces, one-cycle bubble
    word_ready = 1'b1;
    send_str("  7,");
    @(negedge clk);
    check("t2_bubble", char_ready, 0);
    @(negedge clk);
    check("t2_ready_back", char_ready, 1);
    step();
    check("t2_sb", last_word, {1'b0, 4'd1, 16'h0007});

    // 3: over-length run
    send_str("12345 ");
    step(); step();
    check("t3_sb", last_word, {1'b1, 4'd4, 16'h1234});

    // 4: invalid character aborts the run
    e0 = err_cnt; h0 = hs_cnt;
    send_str("1G");
    @(negedge clk);
    check("t4_err_pulse", err_invalid, 1);
    @(negedge clk);
    check("t4_err_low", err_invalid, 0);
    step();
    send_str("2\n");
    step(); step();
    check("t4_err_count", err_cnt - e0, 1);
    check("t4_word_count", hs_cnt - h0, 1);
    check("t4_sb", last_word, {1'b0, 4'd1, 16'h0002});

    // 5: backpressure with a character waiting
    word_ready = 1'b0;
    send_str("ab\n");
    char_in = "C"; char_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_ready_low", char_ready, 0);
      check("t5_word_stable", word_out, 32'h00AB);
      check("t5_valid_held", word_valid, 1);
    end
    step(); word_ready = 1'b1;
    step(); word_ready = 1'b0;
    @(negedge clk);
    check("t5_ready_after", char_ready, 1);
    check("t5_sb", last_word, {1'b0, 4'd2, 16'h00AB});
    step(); char_valid = 1'b0;
    word_ready = 1'b1;
    send_char(8'h0A);
    step(); step();
    check("t5_c_word", last_word, {1'b0, 4'd1, 16'h000C});

    // 6: reset discards a partial word
    send_str("12");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send_str("3");
    send_char(8'h0D);
    step(); step();
    check("t6_sb", last_word, {1'b0, 4'd1, 16'h0003});

    // random stream
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        d = $urandom_range(0, 15);
        if (d < 10) c = 8'(48 + d);
        else if ($urandom_range(0, 1) == 1) c = 8'(55 + d);
        else c = 8'(87 + d);
      end else if (r < 85) begin
        case ($urandom_range(0, 3))
          0: c = 8'h0D;
          1: c = 8'h0A;
          2: c = 8'h20;
          default: c = 8'h2C;
        endcase
      end else begin
        do c = 8'($urandom_range(0, 255)); while (classify(c) != 17);
      end
      send_char(c);
      repeat ($urandom_range(0, 2)) begin
        step();
        word_ready = ($urandom_range(0, 3) != 0);
      end
    end
    send_char(8'h0D);
    rand_rdy = 1'b0;
    word_ready = 1'b1;
    repeat (5) step();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
